// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   ADDR_W / INSTR_W  : program ROM address and word widths
//   RESET_PC          : first fetch address after reset
//   FIFO_DEPTH        : skid entries between ROM and decode (minimum 2)
//   HALT_WORD         : instruction that stops fetch when FETCH_HALT_EN is defined
//   fetch_entry_t     : {pc, instr} pair handed to decode
package fetch_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 10'h000;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Circular index increment for storage whose depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: DEPTH-entry synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          write push_data_i at the clock edge
//   push_data_i     entry to write
//   pop_i           drop the head entry at the clock edge (ignored when empty)
//   flush_i         discard all entries; overrides push
//   count_o         number of valid entries
//   head_o          oldest entry; taken straight from storage, so it is stable
//                   while not popped
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = FIFO_DEPTH,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output entry_t           head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                wr_d = PTR_W'(wrap_inc(32'(wr_q), DEPTH));
            end
            if (do_pop) begin
                rd_d = PTR_W'(wrap_inc(32'(rd_q), DEPTH));
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a synchronous program ROM
// (address in, data one cycle later). Holds the PC, drives the ROM, absorbs the
// read latency and presents {pc, instr} to decode over valid/ready.
// Optional feature macro: FETCH_HALT_EN (adds HALT_WORD parameter and halted output).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rom_en, rom_addr         ROM read request (rom_addr is the PC)
//   rom_data                 ROM word, valid the cycle after rom_en
//   redirect, redirect_addr  load a new PC and flush all fetched/in-flight words
//   instr_valid, instr_ready handshake towards decode
//   instr, instr_pc          head instruction and its PC
//   halted                   (FETCH_HALT_EN) a HALT_WORD has been fetched
module fetch_unit #(
    parameter int unsigned        ADDR_W     = fetch_pkg::ADDR_W,
    parameter int unsigned        INSTR_W    = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned        FIFO_DEPTH = fetch_pkg::FIFO_DEPTH
`ifdef FETCH_HALT_EN
    ,
    parameter logic [INSTR_W-1:0] HALT_WORD  = fetch_pkg::HALT_WORD
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_HALT_EN
    ,
    output logic               halted
`endif
);

    import fetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_word_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              run_q;
    logic              inflight_q, inflight_d;
    logic              stale_q, stale_d;
    logic              halt_w;

    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occ;
    fetch_word_t       push_word;
    fetch_word_t       head_word;

    assign pop = instr_valid & instr_ready;

    // Slots committed once this cycle settles: stored words plus the read in
    // flight, minus the word decode takes now. Keeping this below the depth
    // means every returning read has a free slot, so the FIFO cannot overflow.
    assign occ = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);

    assign issue = run_q & ~redirect & ~halt_w & (occ < OCC_W'(FIFO_DEPTH));
    assign push  = inflight_q & ~stale_q & ~redirect & ~halt_w;

    assign rom_en   = issue;
    assign rom_addr = pc_q;

    assign push_word.pc    = tag_q;
    assign push_word.instr = rom_data;

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (redirect) begin
            halted_d = 1'b0;
        end else if (push && (rom_data == HALT_WORD)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halt_w = halted_q;
    assign halted = halted_q;
`else
    assign halt_w = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        // A read launched in a redirect cycle would return after the flush;
        // flag it so it never lands. Issue is already held off on redirect,
        // so this only guards against the data path ever being loosened.
        stale_d    = redirect;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (issue) begin
            pc_d  = pc_q + 1'b1;
            tag_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            run_q      <= 1'b1;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    fetch_skid_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_word_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (fifo_count),
        .head_o      (head_word)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = head_word.instr;
    assign instr_pc    = head_word.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        redirect = 1'b0;
    logic [9:0]  redirect_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [9:0]  instr_pc;
`ifdef FETCH_HALT_EN
    logic        halted;
`endif

    logic [15:0] rom [1024];

    int          errors = 0;
    int          checks = 0;
    int          accepts = 0;
    int          stall = 0;
    bit          wd_en = 1'b0;
    logic [9:0]  exp_pc = '0;
    logic [9:0]  last_acc_pc = '0;
    logic [15:0] last_acc_instr = '0;

    fetch_unit #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
`ifdef FETCH_HALT_EN
        ,
        .halted        (halted)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: one cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the accepted stream must be consecutive PCs (wrapping at
    // 10 bits) from the last reset/redirect target, each carrying rom[pc].
    task automatic drive(input logic rdy, input logic rd, input logic [9:0] ra);
        instr_ready   = rdy;
        redirect      = rd;
        redirect_addr = ra;
        #1;
        if (rst_n && instr_valid && instr_ready) begin
            check("acc_pc", 32'(instr_pc), 32'(exp_pc));
            check("acc_instr", 32'(instr), 32'(rom[exp_pc]));
            last_acc_pc    = instr_pc;
            last_acc_instr = instr;
            exp_pc         = exp_pc + 10'd1;
            accepts++;
            stall = 0;
        end else if (wd_en && instr_ready && !redirect) begin
            stall++;
            if (stall > 6) begin
                check("stall_bound", 32'(stall), 32'd6);
                stall = 0;
            end
        end
        if (redirect) begin
            exp_pc = ra;
            stall  = 0;
        end
    endtask

    task automatic run_until_accept(input int maxc);
        int a0;
        a0 = accepts;
        for (int i = 0; i < maxc; i++) begin
            drive(1'b1, 1'b0, '0);
            @(negedge clk);
            if (accepts != a0) break;
        end
        check("accept_within_bound", 32'(accepts != a0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 10'h000;
    endtask

    typedef struct {
        logic       rdy;
        logic       en;
        logic [9:0] addr;
        logic       vld;
        logic [9:0] pc;
    } vec_t;

    vec_t       vecs [15];
    logic [9:0] wrap_pcs [4];

    initial begin
        int a0;
        int k;

        for (int i = 0; i < 1024; i++) rom[i] = 16'hA000 + 16'(i);

        // Cycle-by-cycle start-up and backpressure profile, starting at the
        // cycle in which reset is released.
        vecs[0]  = '{1'b1, 1'b0, 10'h0, 1'b0, 10'h0};
        vecs[1]  = '{1'b1, 1'b1, 10'h0, 1'b0, 10'h0};
        vecs[2]  = '{1'b1, 1'b1, 10'h1, 1'b0, 10'h0};
        vecs[3]  = '{1'b1, 1'b1, 10'h2, 1'b1, 10'h0};
        vecs[4]  = '{1'b1, 1'b1, 10'h3, 1'b1, 10'h1};
        for (int i = 5; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 10'h0, 1'b1, 10'h2};
        vecs[11] = '{1'b1, 1'b1, 10'h4, 1'b1, 10'h2};
        vecs[12] = '{1'b1, 1'b1, 10'h5, 1'b1, 10'h3};
        vecs[13] = '{1'b1, 1'b1, 10'h6, 1'b1, 10'h4};
        vecs[14] = '{1'b1, 1'b1, 10'h7, 1'b1, 10'h5};

        wrap_pcs[0] = 10'h3FE;
        wrap_pcs[1] = 10'h3FF;
        wrap_pcs[2] = 10'h000;
        wrap_pcs[3] = 10'h001;

        // Reset state
        @(negedge clk);
        drive(1'b1, 1'b0, '0);
        check("reset_rom_en", 32'(rom_en), 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_HALT_EN
        check("reset_halted", 32'(halted), 32'd0);
`endif
        @(negedge clk);

        // Start-up latency, full throughput, backpressure and release
        rst_n  = 1'b1;
        exp_pc = 10'h000;
        for (int c = 0; c < 15; c++) begin
            drive(vecs[c].rdy, 1'b0, '0);
            check($sformatf("v%0d_rom_en", c), 32'(rom_en), 32'(vecs[c].en));
            if (vecs[c].en) check($sformatf("v%0d_rom_addr", c), 32'(rom_addr), 32'(vecs[c].addr));
            check($sformatf("v%0d_valid", c), 32'(instr_valid), 32'(vecs[c].vld));
            if (vecs[c].vld) begin
                check($sformatf("v%0d_pc", c), 32'(instr_pc), 32'(vecs[c].pc));
                check($sformatf("v%0d_instr", c), 32'(instr), 32'(16'hA000 + 16'(vecs[c].pc)));
            end
            @(negedge clk);
        end

        // Redirect while one word is stored and another read is in flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, '0);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 10'h100);
        check("redir_cycle_rom_en", 32'(rom_en), 32'd0);
        check("redir_cycle_valid", 32'(instr_valid), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, '0);
        check("post_redir_rom_en", 32'(rom_en), 32'd1);
        check("post_redir_rom_addr", 32'(rom_addr), 32'h100);
        check("post_redir_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        run_until_accept(10);
        check("redir_first_pc", 32'(last_acc_pc), 32'h100);
        check("redir_first_instr", 32'(last_acc_instr), 32'hA100);

        // Redirect near the top of the address space: PC wraps
        drive(1'b1, 1'b1, 10'h3FE);
        @(negedge clk);
        a0 = accepts;
        for (int i = 0; i < 20 && (accepts - a0) < 4; i++) begin
            k = accepts;
            drive(1'b1, 1'b0, '0);
            if (accepts != k) check($sformatf("wrap_pc%0d", k - a0), 32'(last_acc_pc), 32'(wrap_pcs[k - a0]));
            @(negedge clk);
        end
        check("wrap_count", 32'(accepts - a0), 32'd4);

        // Asynchronous reset mid-stream
        drive(1'b1, 1'b0, '0);
        check("pre_rst_rom_en", 32'(rom_en), 32'd1);
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rom_en", 32'(rom_en), 32'd0);
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 10'h000;
        run_until_accept(10);
        check("restart_pc", 32'(last_acc_pc), 32'h000);

`ifdef FETCH_HALT_EN
        // Halt on HALT_WORD at pc 3, then resume via redirect
        rom[3] = 16'h0000;
        do_reset();
        a0 = accepts;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, '0);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, '0);
        check("halt_accepts", 32'(accepts - a0), 32'd4);
        check("halt_last_pc", 32'(last_acc_pc), 32'h003);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_rom_en", 32'(rom_en), 32'd0);
        @(negedge clk);
        rom[3] = 16'hA003;
        drive(1'b1, 1'b1, 10'h000);
        @(negedge clk);
        drive(1'b1, 1'b0, '0);
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_rom_en", 32'(rom_en), 32'd1);
        check("unhalt_rom_addr", 32'(rom_addr), 32'h000);
        @(negedge clk);
        run_until_accept(10);
        check("unhalt_first_pc", 32'(last_acc_pc), 32'h000);
`endif

        // Randomized ready/redirect traffic against the stream model
        wd_en = 1'b1;
        stall = 0;
        a0 = accepts;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), 10'($urandom));
            @(negedge clk);
        end
        wd_en = 1'b0;
        check("random_throughput", 32'((accepts - a0) > 1000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
